// File: rtl/modmul_serial_pkg.sv
// Shared x25519 field constants and multiply-handshake state encodings.
// Sequencers that drive the shared multiplier import this package so that
// they agree with the responder on widths, modulus and FSM encodings.
package modmul_serial_pkg;

    // Field element width: p = 2^255 - 19.
    localparam int WIDTH  = 255;

    // 2^255 is congruent to 19 mod p; used to fold the top bits back in.
    localparam int FOLD_C = 19;

    // p = 2^255 - 19: 250 ones above the low five bits 0b01101.
    localparam logic [WIDTH-1:0] P_MOD = {{250{1'b1}}, 5'b01101};

    // Responder-side states of the multiply handshake.
    typedef enum logic [1:0] {
        MM_IDLE = 2'd0,
        MM_RUN  = 2'd1,
        MM_DONE = 2'd2
    } mm_state_e;

endpackage : modmul_serial_pkg

// File: rtl/modmul_serial_step.sv
// One MSB-first radix-2 step of the serial modular multiplier:
//   r = (2a + (b ? y : 0)) mod p, with a < p and y any WIDTH-bit value.
// Purely combinational so it can be unit-tested and reused by a wider-radix
// variant.
module modmul_step #(
    parameter int WIDTH  = modmul_serial_pkg::WIDTH,
    parameter int FOLD_C = modmul_serial_pkg::FOLD_C
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             b_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] r_o
);

    // Modulus for this width: 2^WIDTH - FOLD_C.
    localparam logic [WIDTH-1:0] P_L = {WIDTH{1'b1}} - WIDTH'(FOLD_C - 1);

    logic [WIDTH+1:0] s_s;      // 2a + addend, below 3*2^WIDTH
    logic [WIDTH:0]   t_s;      // folded value, below p + 76
    logic             t_ge_p_s; // folded value needs one subtraction of p

    // Double, conditionally add y, fold the two overflow bits by FOLD_C, and
    // make the result canonical with a single conditional subtract.
    always_comb begin
        s_s = {1'b0, a_i, 1'b0} + {2'b00, (b_i ? y_i : {WIDTH{1'b0}})};
        t_s = {1'b0, s_s[WIDTH-1:0]}
            + ((WIDTH+1)'(s_s[WIDTH+1:WIDTH]) * (WIDTH+1)'(FOLD_C));
        t_ge_p_s = (t_s >= {1'b0, P_L});
        if (t_ge_p_s) begin
            r_o = WIDTH'(t_s - {1'b0, P_L});
        end else begin
            r_o = t_s[WIDTH-1:0];
        end
    end

endmodule : modmul_step

// File: rtl/modmul_serial.sv
// Bit-serial modular multiplier Z = X*Y mod (2^255 - 19), responder side of
// the shared multiply handshake. One MSB-first iteration per clock over the
// latched multiplicand; the canonical result is written to Z on the last
// iteration together with res_valid, while req_busy drops on the same edge.
module modmul_serial #(
    parameter int WIDTH  = modmul_serial_pkg::WIDTH,
    parameter int FOLD_C = modmul_serial_pkg::FOLD_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             req_busy,
    output logic             res_valid,
    input  logic             res_ready
);

    import modmul_serial_pkg::*;

    mm_state_e        state_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] xr_q;
    logic [WIDTH-1:0] yr_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] z_q;
    logic             req_ready_q;
    logic             req_busy_q;
    logic             res_valid_q;

    // Next accumulator value: one radix-2 step on the current multiplicand bit.
    modmul_step #(
        .WIDTH  (WIDTH),
        .FOLD_C (FOLD_C)
    ) u_step (
        .a_i (acc_q),
        .b_i (xr_q[cnt_q]),
        .y_i (yr_q),
        .r_o (acc_d)
    );

    // Handshake FSM, iteration counter and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MM_IDLE;
            cnt_q       <= 8'd0;
            xr_q        <= {WIDTH{1'b0}};
            yr_q        <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            z_q         <= {WIDTH{1'b0}};
            req_ready_q <= 1'b0;
            req_busy_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MM_IDLE: begin
                    if (req_valid) begin
                        xr_q        <= X;
                        yr_q        <= Y;
                        acc_q       <= {WIDTH{1'b0}};
                        cnt_q       <= 8'(WIDTH - 1);
                        req_ready_q <= 1'b1;
                        req_busy_q  <= 1'b1;
                        state_q     <= MM_RUN;
                    end else begin
                        req_ready_q <= 1'b0;
                    end
                end
                MM_RUN: begin
                    // Accept pulse lasts exactly the one cycle after acceptance.
                    req_ready_q <= 1'b0;
                    acc_q       <= acc_d;
                    if (cnt_q == 8'd0) begin
                        z_q         <= acc_d;
                        res_valid_q <= 1'b1;
                        req_busy_q  <= 1'b0;
                        state_q     <= MM_DONE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                MM_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= MM_IDLE;
                    end else begin
                        res_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= MM_IDLE;
                    req_ready_q <= 1'b0;
                    req_busy_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Z         = z_q;
    assign req_ready = req_ready_q;
    assign req_busy  = req_busy_q;
    assign res_valid = res_valid_q;

endmodule : modmul_serial

// File: tb/tb_modmul_serial.sv
// Self-checking bench for modmul_serial: directed vector table, a few random
// pairs against a wide-arithmetic reference, plus handshake corner sequences
// (withheld consume, reset mid-iteration).
module tb_modmul_serial;

    localparam int W = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic [W-1:0] Z;
    logic         req_valid;
    logic         req_ready;
    logic         req_busy;
    logic         res_valid;
    logic         res_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] P;
    logic [W-1:0] ALL1;
    logic [W-1:0] HALF;

    always #5 clk = ~clk;

    modmul_serial #(
        .WIDTH  (W),
        .FOLD_C (19)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_busy  (req_busy),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: full 510-bit product reduced with the simulator's own modulo.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] pp;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        pp   = {{W{1'b0}}, P};
        return W'(prod % pp);
    endfunction

    // Issue one multiply, measure handshake timing, optionally consume result.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit consume,
                          output logic [W-1:0] z, output int lat, output int rdy_w,
                          output bit busy_ok, output bit acc_ok);
        int wait_c;
        lat     = 0;
        rdy_w   = 0;
        busy_ok = 1'b1;
        acc_ok  = 1'b1;
        z       = {W{1'b0}};
        @(negedge clk);
        X         = x;
        Y         = y;
        req_valid = 1'b1;
        wait_c    = 0;
        do begin
            @(negedge clk);
            wait_c++;
        end while (!req_ready && wait_c < 8);
        if (!req_ready) begin
            acc_ok    = 1'b0;
            req_valid = 1'b0;
            return;
        end
        if (!req_busy) busy_ok = 1'b0;
        // Drop the request and scramble operands: latched values must be used.
        req_valid = 1'b0;
        X         = ~x;
        Y         = ~y;
        rdy_w     = 1;
        while (!res_valid && lat < 400) begin
            @(negedge clk);
            lat++;
            if (req_ready) rdy_w++;
            if (!res_valid && !req_busy) busy_ok = 1'b0;
            if (res_valid && req_busy) busy_ok = 1'b0;
        end
        z = Z;
        if (consume) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            check("res_valid_drop", W'(res_valid), W'(0));
        end
    endtask

    task automatic op_and_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                                input logic [W-1:0] exp);
        logic [W-1:0] z;
        int           lat;
        int           rdy_w;
        bit           busy_ok;
        bit           acc_ok;
        run_op(x, y, 1'b1, z, lat, rdy_w, busy_ok, acc_ok);
        check({name, "_accept"}, W'(acc_ok), W'(1));
        check({name, "_z"}, z, exp);
        check({name, "_latency"}, W'(lat), W'(255));
        check({name, "_ready_width"}, W'(rdy_w), W'(1));
        check({name, "_busy"}, W'(busy_ok), W'(1));
    endtask

    initial begin
        logic [W-1:0] z;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        int           lat;
        int           rdy_w;
        bit           busy_ok;
        bit           acc_ok;

        P    = {{250{1'b1}}, 5'b01101};
        ALL1 = {W{1'b1}};
        HALF = (P >> 1) + {{(W-1){1'b0}}, 1'b1};

        vecs.push_back('{x: W'(2),       y: W'(3),        z: W'(6),          name: "two_times_three"});
        vecs.push_back('{x: P - W'(1),   y: P - W'(1),    z: W'(1),          name: "pm1_sq"});
        vecs.push_back('{x: W'(0),       y: P - W'(1),    z: W'(0),          name: "zero_x"});
        vecs.push_back('{x: ALL1,        y: W'(1),        z: W'(18),         name: "noncanon_x"});
        vecs.push_back('{x: ALL1,        y: ALL1,         z: W'(324),        name: "all_ones_sq"});
        vecs.push_back('{x: W'(2),       y: HALF,         z: W'(1),          name: "inverse_of_two"});
        vecs.push_back('{x: P,           y: W'(12345),    z: W'(0),          name: "x_eq_p"});
        vecs.push_back('{x: W'(1) << 254, y: W'(2),       z: W'(19),         name: "wrap_2p255"});
        vecs.push_back('{x: P - W'(1),   y: W'(2),        z: P - W'(2),      name: "neg_one_times_two"});
        vecs.push_back('{x: ALL1,        y: P - W'(1),    z: P - W'(18),     name: "noncanon_neg"});

        rst       = 1'b1;
        X         = {W{1'b0}};
        Y         = {W{1'b0}};
        req_valid = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_z", Z, W'(0));
        check("reset_req_ready", W'(req_ready), W'(0));
        check("reset_req_busy", W'(req_busy), W'(0));
        check("reset_res_valid", W'(res_valid), W'(0));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            op_and_check(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].z);
        end

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < 8; k++) begin
                rx = {rx[W-33:0], 32'($urandom)};
                ry = {ry[W-33:0], 32'($urandom)};
            end
            op_and_check("random", rx, ry, model(rx, ry));
        end

        // Result withheld: outputs stay put and new requests are refused.
        run_op(W'(6), W'(7), 1'b0, z, lat, rdy_w, busy_ok, acc_ok);
        check("hold_first_z", z, W'(42));
        for (int i = 0; i < 10; i++) begin
            req_valid = i[0];
            X         = W'(9);
            Y         = W'(9);
            @(negedge clk);
            check("hold_res_valid", W'(res_valid), W'(1));
            check("hold_z", Z, W'(42));
            check("hold_req_ready", W'(req_ready), W'(0));
            check("hold_req_busy", W'(req_busy), W'(0));
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("hold_release", W'(res_valid), W'(0));
        op_and_check("after_hold", W'(11), W'(13), W'(143));

        // Reset during iteration 100 aborts with no partial result on Z.
        @(negedge clk);
        X         = W'(123456789);
        Y         = P - W'(3);
        req_valid = 1'b1;
        @(negedge clk);
        check("abort_accept", W'(req_ready), W'(1));
        req_valid = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_z", Z, W'(0));
        check("abort_req_ready", W'(req_ready), W'(0));
        check("abort_req_busy", W'(req_busy), W'(0));
        check("abort_res_valid", W'(res_valid), W'(0));
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_no_completion", W'(res_valid), W'(0));
        op_and_check("after_abort", W'(5), W'(7), W'(35));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_modmul_serial
